rename_dispatch: RTL

Register-rename and dispatch stage for the out-of-order MIPS core: it sits between decode and the instruction queue. It maps architectural sources and destinations to physical registers and allocates destinations from a free list. It owns the physical busy-bit table that the instruction queue reads for wakeup, and it delivers renamed instructions to the queue through a valid/ready handshake. It also retires old mappings on commit and restores the speculative map on a branch flush.

---
 rtl/rename_dispatch.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/rename_dispatch.sv
// Register rename and dispatch stage between decode and the instruction queue.
// Maps architectural source/destination registers onto physical tags, allocates
// destinations from a free vector, owns the physical busy table read for wakeup,
// and presents renamed instructions to the queue through a valid/ready handshake.
// Commit updates the retirement map and frees the superseded tag; flush restores
// the speculative map from the retirement map.
//
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   in_valid / in_ready               decode handshake (in_ready is combinational)
//   in_rs, in_rt, in_rw, in_uses_*    architectural operands and use flags
//   in_instr_count                    program-order sequence number
//   out_valid / out_ready             queue write handshake
//   out_*_phys, out_uses_*, out_instr_count  registered renamed instruction
//   busy_bits                         registered busy table, 1 = value pending
//   wb_valid, wb_phys                 writeback completion, clears busy
//   commit_*                          in-order retirement
//   flush                             squash all uncommitted instructions
module rename_dispatch #(
    parameter int unsigned NUM_ARCH = 32,
    parameter int unsigned NUM_PHYS = 64,
    parameter int unsigned PHYS_W   = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4:0]          in_rs,
    input  logic [4:0]          in_rt,
    input  logic [4:0]          in_rw,
    input  logic                in_uses_rs,
    input  logic                in_uses_rt,
    input  logic                in_uses_rw,
    input  logic [31:0]         in_instr_count,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PHYS_W-1:0]   out_rs_phys,
    output logic [PHYS_W-1:0]   out_rt_phys,
    output logic [PHYS_W-1:0]   out_rw_phys,
    output logic [PHYS_W-1:0]   out_old_rw_phys,
    output logic                out_uses_rs,
    output logic                out_uses_rt,
    output logic                out_uses_rw,
    output logic [31:0]         out_instr_count,
    output logic [NUM_PHYS-1:0] busy_bits,
    input  logic                wb_valid,
    input  logic [PHYS_W-1:0]   wb_phys,
    input  logic                commit_valid,
    input  logic [4:0]          commit_rw_arch,
    input  logic [PHYS_W-1:0]   commit_rw_phys,
    input  logic [PHYS_W-1:0]   commit_old_phys,
    input  logic                flush
);

    logic [PHYS_W-1:0]   spec_map    [NUM_ARCH];
    logic [PHYS_W-1:0]   ret_map     [NUM_ARCH];
    logic [PHYS_W-1:0]   ret_map_nxt [NUM_ARCH];
    logic [NUM_PHYS-1:0] free_q;
    logic [NUM_PHYS-1:0] busy_q;
    logic [NUM_PHYS-1:0] free_nxt;
    logic [NUM_PHYS-1:0] busy_nxt;
    logic [NUM_PHYS-1:0] ret_used;
    logic [PHYS_W-1:0]   alloc_tag;
    logic                dest_needed;
    logic                accept;
    logic                commit_en;

    assign dest_needed = in_uses_rw && (in_rw != 5'd0);
    assign commit_en   = commit_valid && (commit_rw_arch != 5'd0);
    assign in_ready    = !flush && (!out_valid || out_ready) && ((|free_q) || !dest_needed);
    assign accept      = in_valid && in_ready;
    assign busy_bits   = busy_q;

    // Lowest-index free tag; tag 0 is never free so 0 means "none".
    always_comb begin
        alloc_tag = '0;
        for (int i = int'(NUM_PHYS) - 1; i >= 1; i--) begin
            if (free_q[i]) alloc_tag = PHYS_W'(i);
        end
    end

    // Retirement map including this cycle's commit, and the tags it references.
    always_comb begin
        ret_used = '0;
        for (int i = 0; i < int'(NUM_ARCH); i++) begin
            ret_map_nxt[i] = ret_map[i];
        end
        if (commit_en) ret_map_nxt[commit_rw_arch] = commit_rw_phys;
        for (int i = 0; i < int'(NUM_ARCH); i++) begin
            ret_used[ret_map_nxt[i]] = 1'b1;
        end
    end

    // Non-flush free/busy update: writeback clear, allocation, commit release.
    always_comb begin
        free_nxt = free_q;
        busy_nxt = busy_q;
        if (wb_valid && (wb_phys != '0)) busy_nxt[wb_phys] = 1'b0;
        if (accept && dest_needed) begin
            free_nxt[alloc_tag] = 1'b0;
            busy_nxt[alloc_tag] = 1'b1;
        end
        if (commit_en && (commit_old_phys != '0)) free_nxt[commit_old_phys] = 1'b1;
    end

    // Map tables, free/busy vectors and output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_ARCH); i++) begin
                spec_map[i] <= PHYS_W'(i);
                ret_map[i]  <= PHYS_W'(i);
            end
            for (int i = 0; i < int'(NUM_PHYS); i++) begin
                free_q[i] <= (i >= int'(NUM_ARCH));
            end
            busy_q          <= '0;
            out_valid       <= 1'b0;
            out_rs_phys     <= '0;
            out_rt_phys     <= '0;
            out_rw_phys     <= '0;
            out_old_rw_phys <= '0;
            out_uses_rs     <= 1'b0;
            out_uses_rt     <= 1'b0;
            out_uses_rw     <= 1'b0;
            out_instr_count <= '0;
        end else begin
            if (commit_en) ret_map[commit_rw_arch] <= commit_rw_phys;
            if (flush) begin
                for (int i = 0; i < int'(NUM_ARCH); i++) begin
                    spec_map[i] <= ret_map_nxt[i];
                end
                free_q    <= ~ret_used;
                busy_q    <= '0;
                out_valid <= 1'b0;
            end else begin
                free_q <= free_nxt;
                busy_q <= busy_nxt;
                if (accept) begin
                    // Sources see the map before this instruction's own update.
                    out_valid       <= 1'b1;
                    out_rs_phys     <= in_uses_rs ? spec_map[in_rs] : '0;
                    out_rt_phys     <= in_uses_rt ? spec_map[in_rt] : '0;
                    out_rw_phys     <= dest_needed ? alloc_tag : '0;
                    out_old_rw_phys <= dest_needed ? spec_map[in_rw] : '0;
                    out_uses_rs     <= in_uses_rs;
                    out_uses_rt     <= in_uses_rt;
                    out_uses_rw     <= in_uses_rw;
                    out_instr_count <= in_instr_count;
                    if (dest_needed) spec_map[in_rw] <= alloc_tag;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
